clk_rst_sequencer: RTL and testbench

- Controls the pixel-clock MMCM: drives its reset, waits for LOCKED, lets it settle, then releases the downstream system reset.
- Watches for loss of lock and re-sequences automatically, with bounded retries and a sticky fault.
- Runs on the free-running board oscillator (100 MHz), because the pixel clock is not valid until lock.
- Sits between the top level and the VGA clock generator; its `sys_rst_n` feeds the per-domain reset synchronisers.

---
 rtl/clk_seq_pkg.sv | 23 ++
 rtl/sync_bit.sv | 23 ++
 rtl/clk_rst_sequencer.sv | 123 ++++++++++++
 tb/tb_clk_rst_sequencer.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/clk_seq_pkg.sv
// Shared types and helpers for the MMCM clock/reset sequencer.
package clk_seq_pkg;

  typedef enum logic [2:0] {
    ST_HOLD      = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_SETTLE    = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAULT     = 3'd4
  } seq_state_t;

  // Width of a counter able to hold the largest of the three phase lengths.
  function automatic int unsigned cnt_width(input int unsigned hold_cycles,
                                            input int unsigned lock_timeout,
                                            input int unsigned settle_cycles);
    int unsigned m;
    m = hold_cycles;
    if (lock_timeout > m) m = lock_timeout;
    if (settle_cycles > m) m = settle_cycles;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/sync_bit.sv
// Multi-flop single-bit synchroniser with asynchronous active-low reset.
module sync_bit #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/clk_rst_sequencer.sv
// Sequences the pixel-clock MMCM: reset hold, lock wait, settle, run,
// with automatic re-sequencing on lock loss and a sticky fault after retries.
module clk_rst_sequencer
  import clk_seq_pkg::*;
#(
  parameter int unsigned RST_HOLD_CYCLES = 16,
  parameter int unsigned LOCK_TIMEOUT    = 100000,
  parameter int unsigned SETTLE_CYCLES   = 256,
  parameter int unsigned MAX_RETRIES     = 3,
  parameter int unsigned SYNC_STAGES     = 2
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               mmcm_locked,
  input  logic                               restart,
  output logic                               mmcm_rst,
  output logic                               sys_rst_n,
  output logic                               ready,
  output logic                               fault,
  output logic [2:0]                         state_o,
  output logic [$clog2(MAX_RETRIES+1)-1:0]   retry_cnt
);

  localparam int unsigned TW = cnt_width(RST_HOLD_CYCLES, LOCK_TIMEOUT, SETTLE_CYCLES);
  localparam int unsigned RW = $clog2(MAX_RETRIES + 1);

  localparam logic [TW-1:0] HOLD_LAST    = TW'(RST_HOLD_CYCLES - 1);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(LOCK_TIMEOUT - 1);
  localparam logic [TW-1:0] SETTLE_LAST  = TW'(SETTLE_CYCLES - 1);
  localparam logic [RW-1:0] RETRY_LAST   = RW'(MAX_RETRIES - 1);
  localparam logic [RW-1:0] RETRY_MAX    = RW'(MAX_RETRIES);

  logic          lock_s;
  seq_state_t    state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [RW-1:0] retry_q, retry_d;
  logic          fail;
  logic          mmcm_rst_q, sys_rst_n_q, ready_q, fault_q;

  sync_bit #(
    .STAGES (SYNC_STAGES)
  ) u_lock_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (mmcm_locked),
    .q_o   (lock_s)
  );

  always_comb begin
    state_d = state_q;
    retry_d = retry_q;
    timer_d = timer_q;
    fail    = 1'b0;

    if (restart) begin
      state_d = ST_HOLD;
      retry_d = '0;
    end else begin
      case (state_q)
        ST_HOLD: begin
          if (timer_q == HOLD_LAST) state_d = ST_WAIT_LOCK;
        end
        ST_WAIT_LOCK: begin
          if (lock_s)                       state_d = ST_SETTLE;
          else if (timer_q == TIMEOUT_LAST) fail    = 1'b1;
        end
        ST_SETTLE: begin
          if (!lock_s)                     state_d = ST_WAIT_LOCK;
          else if (timer_q == SETTLE_LAST) state_d = ST_RUN;
        end
        ST_RUN: begin
          if (!lock_s) fail = 1'b1;
        end
        ST_FAULT: begin
          state_d = ST_FAULT;
        end
        default: begin
          state_d = ST_HOLD;
        end
      endcase
    end

    if (fail) begin
      retry_d = (retry_q == RETRY_MAX) ? retry_q : retry_q + RW'(1);
      state_d = (retry_q == RETRY_LAST) ? ST_FAULT : ST_HOLD;
    end

    // A restart inside HOLD is not a state change but must still restart the hold count.
    if (restart || (state_d != state_q)) begin
      timer_d = '0;
    end else if (state_q inside {ST_HOLD, ST_WAIT_LOCK, ST_SETTLE}) begin
      timer_d = timer_q + TW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_HOLD;
      timer_q     <= '0;
      retry_q     <= '0;
      mmcm_rst_q  <= 1'b1;
      sys_rst_n_q <= 1'b0;
      ready_q     <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      retry_q     <= retry_d;
      mmcm_rst_q  <= (state_d == ST_HOLD) || (state_d == ST_FAULT);
      sys_rst_n_q <= (state_d == ST_RUN);
      ready_q     <= (state_d == ST_RUN);
      fault_q     <= (state_d == ST_FAULT);
    end
  end

  assign mmcm_rst  = mmcm_rst_q;
  assign sys_rst_n = sys_rst_n_q;
  assign ready     = ready_q;
  assign fault     = fault_q;
  assign state_o   = state_q;
  assign retry_cnt = retry_q;

endmodule

// File: tb/tb_clk_rst_sequencer.sv
// Self-checking bench: timestamp-based phase model compared every cycle,
// plus directed scenarios with hand-computed edge counts.
module tb_clk_rst_sequencer;

  localparam int HOLD_C = 4;
  localparam int TO_C   = 20;
  localparam int SET_C  = 8;
  localparam int MAXR   = 2;
  localparam int SYNC   = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       mmcm_locked = 1'b0;
  logic       restart = 1'b0;
  logic       mmcm_rst, sys_rst_n, ready, fault;
  logic [2:0] state_o;
  logic [1:0] retry_cnt;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;
  int n;
  bit glitch_rst;

  always #5 clk = ~clk;

  clk_rst_sequencer #(
    .RST_HOLD_CYCLES (HOLD_C),
    .LOCK_TIMEOUT    (TO_C),
    .SETTLE_CYCLES   (SET_C),
    .MAX_RETRIES     (MAXR),
    .SYNC_STAGES     (SYNC)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .mmcm_locked (mmcm_locked),
    .restart     (restart),
    .mmcm_rst    (mmcm_rst),
    .sys_rst_n   (sys_rst_n),
    .ready       (ready),
    .fault       (fault),
    .state_o     (state_o),
    .retry_cnt   (retry_cnt)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // Model: phase + entry timestamp; lock_s seen at edge e is the raw sample from edge e-SYNC.
  int m_state, m_retry, m_edge, m_entry, m_el, m_old;
  bit m_ls;
  bit hist[$];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_state = 0;
      m_retry = 0;
      m_edge  = 0;
      m_entry = 0;
      hist.delete();
    end else begin
      m_ls = (hist.size() >= SYNC) ? hist[hist.size()-SYNC] : 1'b0;
      m_el = m_edge - m_entry + 1;
      m_old = m_state;
      if (restart) begin
        m_retry = 0;
        m_state = 0;
        m_entry = m_edge + 1;
      end else begin
        case (m_state)
          0: if (m_el >= HOLD_C) m_state = 1;
          1: begin
            if (m_ls) m_state = 2;
            else if (m_el >= TO_C) m_state = (m_retry == MAXR-1) ? 4 : 0;
            if (!m_ls && m_el >= TO_C && m_retry < MAXR) m_retry++;
          end
          2: begin
            if (!m_ls) m_state = 1;
            else if (m_el >= SET_C) m_state = 3;
          end
          3: if (!m_ls) begin
            m_state = (m_retry == MAXR-1) ? 4 : 0;
            if (m_retry < MAXR) m_retry++;
          end
          default: m_state = 4;
        endcase
        if (m_state != m_old) m_entry = m_edge + 1;
      end
      hist.push_back(mmcm_locked);
      if (hist.size() > 8) void'(hist.pop_front());
      m_edge++;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("cyc_state", state_o, m_state);
      chk("cyc_mmcm_rst", mmcm_rst, (m_state == 0) || (m_state == 4));
      chk("cyc_sys_rst_n", sys_rst_n, m_state == 3);
      chk("cyc_ready", ready, m_state == 3);
      chk("cyc_fault", fault, m_state == 4);
      chk("cyc_retry", retry_cnt, m_retry);
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_mmcm_rst"}, mmcm_rst, 1);
    chk({tag, "_sys_rst_n"}, sys_rst_n, 0);
    chk({tag, "_ready"}, ready, 0);
    chk({tag, "_fault"}, fault, 0);
    chk({tag, "_state"}, state_o, 0);
    chk({tag, "_retry"}, retry_cnt, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    #1 rst_n = 1'b0;
    repeat (3) step();
    chk_en = 1'b1;
    chk_reset_vals("rst");
    rst_n = 1'b1;

    // Clean start: HOLD length, then lock raised 6 cycles after mmcm_rst falls
    n = 0; do begin step(); n++; end while (mmcm_rst && n < 50);
    chk("hold_len", n, 4);
    repeat (6) step();
    mmcm_locked = 1'b1;
    // Count includes the first edge that samples mmcm_locked high
    n = 0; do begin step(); n++; end while (!ready && n < 50);
    chk("lock_to_ready", n, 11);
    chk("run_sys_rst_n", sys_rst_n, 1);
    chk("run_retry", retry_cnt, 0);
    chk("run_state", state_o, 3);

    // Lock loss in RUN
    repeat (3) step();
    mmcm_locked = 1'b0;
    n = 0; do begin step(); n++; end while (ready && n < 50);
    chk("loss_to_ready_low", n, 3);
    chk("loss_sys_rst_n", sys_rst_n, 0);
    n = 0; do begin step(); n++; end while (mmcm_rst && n < 50);
    chk("rehold_len", n, 4);
    chk("loss_retry", retry_cnt, 1);
    mmcm_locked = 1'b1;
    n = 0; do begin step(); n++; end while (!ready && n < 60);
    chk("relock_ready", ready, 1);
    chk("relock_retry_kept", retry_cnt, 1);

    // restart on the same edge the FSM would see the RUN lock loss
    repeat (2) step();
    mmcm_locked = 1'b0;
    step(); step();
    restart = 1'b1;
    step();
    restart = 1'b0;
    chk("rs_loss_state", state_o, 0);
    chk("rs_loss_retry", retry_cnt, 0);
    chk("rs_loss_mmcm_rst", mmcm_rst, 1);

    // Two lock timeouts -> FAULT
    n = 0; do begin step(); n++; end while (mmcm_rst && n < 50);
    chk("hold_after_restart", n, 4);
    n = 0; do begin step(); n++; end while (!mmcm_rst && n < 50);
    chk("timeout1_len", n, 20);
    chk("timeout1_retry", retry_cnt, 1);
    chk("timeout1_state", state_o, 0);
    n = 0; do begin step(); n++; end while (mmcm_rst && n < 50);
    chk("retry_hold_len", n, 4);
    n = 0; do begin step(); n++; end while (!fault && n < 50);
    chk("timeout2_len", n, 20);
    chk("fault_retry", retry_cnt, 2);
    chk("fault_state", state_o, 4);
    chk("fault_mmcm_rst", mmcm_rst, 1);
    chk("fault_sys_rst_n", sys_rst_n, 0);
    mmcm_locked = 1'b1;
    repeat (10) step();
    chk("fault_sticky", fault, 1);
    chk("fault_sticky_state", state_o, 4);

    // restart out of FAULT
    restart = 1'b1;
    step();
    restart = 1'b0;
    chk("fault_rs_state", state_o, 0);
    chk("fault_rs_retry", retry_cnt, 0);
    chk("fault_rs_fault", fault, 0);

    // One-cycle lock drop inside SETTLE
    n = 0; do begin step(); n++; end while (state_o != 3'd2 && n < 60);
    chk("reach_settle", state_o, 2);
    repeat (4) step();
    mmcm_locked = 1'b0;
    step();
    mmcm_locked = 1'b1;
    glitch_rst = 1'b0;
    n = 0; do begin step(); n++; glitch_rst |= mmcm_rst; end while (state_o != 3'd1 && n < 10);
    chk("glitch_to_wait", n, 2);
    n = 0; do begin step(); n++; glitch_rst |= mmcm_rst; end while (state_o != 3'd2 && n < 10);
    chk("glitch_back_settle", state_o, 2);
    chk("glitch_no_rst_pulse", glitch_rst, 0);
    chk("glitch_retry", retry_cnt, 0);
    n = 0; do begin step(); n++; end while (!ready && n < 50);
    chk("resettle_len", n, 8);

    // Asynchronous reset mid-SETTLE
    mmcm_locked = 1'b0;
    n = 0; do begin step(); n++; end while (!mmcm_rst && n < 20);
    mmcm_locked = 1'b1;
    n = 0; do begin step(); n++; end while (state_o != 3'd2 && n < 60);
    repeat (2) step();
    chk("pre_arst_settle_state", state_o, 2);
    chk("pre_arst_settle_retry", retry_cnt, 1);
    rst_n = 1'b0;
    #1;
    chk_reset_vals("arst_settle");
    step();
    rst_n = 1'b1;

    // Asynchronous reset mid-RUN
    n = 0; do begin step(); n++; end while (!ready && n < 80);
    repeat (3) step();
    chk("pre_arst_run_ready", ready, 1);
    rst_n = 1'b0;
    #1;
    chk_reset_vals("arst_run");
    step();
    rst_n = 1'b1;
    repeat (5) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
